// File: rtl/vga_timing_gen_pkg.sv
// Common types and helpers for the VGA raster source.
`include "macros.sv"

package vga_timing_gen_pkg;

  // Raster counters are 11 bits wide, enough for both 1055 and 627.
  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  // True when lo <= val < hi; used for the sync windows.
  function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Emits a one-cycle tick on every N-th strobe. The tick is registered on the
// same edge that consumes the N-th strobe, so it lines up with whatever
// state the strobe announced.
module frame_tick_counter #(
  parameter int N = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic tick
);

  localparam int         W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // Advance on each strobe; the >= compare pulls any stray value back to 0.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (strobe) begin
      if (cnt_q >= LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count and tick registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/macros.sv
// Shared VGA bus layout and 800x600@60 timing defaults.
// Overlay stages include this file to pack and unpack the 38-bit bus.
`ifndef VGA_MACROS_SV
`define VGA_MACROS_SV

// Bus layout: {vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]}
`define VGA_BUS_SIZE 38
`define VGA_RGB      11:0
`define VGA_HBLNK    12
`define VGA_HSYNC    13
`define VGA_HCOUNT   24:14
`define VGA_VBLNK    25
`define VGA_VSYNC    26
`define VGA_VCOUNT   37:27

// 800x600@60 Hz with a 40 MHz pixel clock
`define VGA_800x600_H_VISIBLE      800
`define VGA_800x600_H_SYNC_START   840
`define VGA_800x600_H_SYNC_LEN     128
`define VGA_800x600_H_TOTAL        1056
`define VGA_800x600_V_VISIBLE      600
`define VGA_800x600_V_SYNC_START   601
`define VGA_800x600_V_SYNC_LEN     4
`define VGA_800x600_V_TOTAL        628
`define VGA_800x600_FRAMES_PER_SEC 60

`endif

// File: rtl/vga_timing_gen.sv
// Source end of the VGA bus: 800x600@60 raster counters, sync and blanking,
// rgb forced to zero, plus frame_start and a once-per-second tick.
`include "macros.sv"

module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE      = `VGA_800x600_H_VISIBLE,
  parameter int H_SYNC_START   = `VGA_800x600_H_SYNC_START,
  parameter int H_SYNC_LEN     = `VGA_800x600_H_SYNC_LEN,
  parameter int H_TOTAL        = `VGA_800x600_H_TOTAL,
  parameter int V_VISIBLE      = `VGA_800x600_V_VISIBLE,
  parameter int V_SYNC_START   = `VGA_800x600_V_SYNC_START,
  parameter int V_SYNC_LEN     = `VGA_800x600_V_SYNC_LEN,
  parameter int V_TOTAL        = `VGA_800x600_V_TOTAL,
  parameter int FRAMES_PER_SEC = `VGA_800x600_FRAMES_PER_SEC
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [`VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic                     frame_start,
  output logic                     one_sec_tick
);

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_LO  = cnt_t'(H_SYNC_START);
  localparam cnt_t HS_HI  = cnt_t'(H_SYNC_START + H_SYNC_LEN);
  localparam cnt_t VS_LO  = cnt_t'(V_SYNC_START);
  localparam cnt_t VS_HI  = cnt_t'(V_SYNC_START + V_SYNC_LEN);

  logic rst_meta_q, rst_sync_q;
  logic load_en, count_en, frame_wrap;

  cnt_t h_q, h_d, v_q, v_d;
  logic hsync_q, hsync_d, hblnk_q, hblnk_d;
  logic vsync_q, vsync_d, vblnk_q, vblnk_d;
  logic frame_start_q, frame_start_d;

  // Release synchroniser: assert asynchronously, release two edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  // load_en: the edge that presents (0,0); count_en: every edge after that.
  assign load_en  = ~rst_meta_q;
  assign count_en = ~rst_sync_q;

  // Next raster position; terminal compares use >= so bad states recover.
  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    frame_wrap = 1'b0;
    if (!count_en) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q >= H_LAST) begin
      h_d = '0;
      if (v_q >= V_LAST) begin
        v_d        = '0;
        frame_wrap = 1'b1;
      end else begin
        v_d = v_q + 1'b1;
      end
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // Decode sync/blank from the next position so they register alongside it.
  always_comb begin
    hblnk_d       = load_en && (h_d >= H_VIS);
    hsync_d       = load_en && in_window(h_d, HS_LO, HS_HI);
    vblnk_d       = load_en && (v_d >= V_VIS);
    vsync_d       = load_en && in_window(v_d, VS_LO, VS_HI);
    frame_start_d = load_en && (h_d == '0) && (v_d == '0);
  end

  // Output registers, all cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      hblnk_q       <= hblnk_d;
      vsync_q       <= vsync_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Pack the bus; rgb is left at zero for the overlays to fill in.
  always_comb begin
    vga_bus_out              = '0;
    vga_bus_out[`VGA_VCOUNT] = v_q;
    vga_bus_out[`VGA_VSYNC]  = vsync_q;
    vga_bus_out[`VGA_VBLNK]  = vblnk_q;
    vga_bus_out[`VGA_HCOUNT] = h_q;
    vga_bus_out[`VGA_HSYNC]  = hsync_q;
    vga_bus_out[`VGA_HBLNK]  = hblnk_q;
    vga_bus_out[`VGA_RGB]    = 12'h000;
  end

  assign frame_start = frame_start_q;

  frame_tick_counter #(
    .N(FRAMES_PER_SEC)
  ) u_sec_tick (
    .clk   (clk),
    .rst   (rst),
    .strobe(frame_wrap),
    .tick  (one_sec_tick)
  );

endmodule
